// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// The optional parity stage is selected by the UART_RX_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int DATA_BITS_DEFAULT  = 8;

    // Expected parity bit for the low nbits of data (odd=1 selects odd parity).
    function automatic logic parity_bit(input logic [7:0] data,
                                        input int unsigned nbits,
                                        input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx pin; flops reset to the idle level (1).
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!reset_n) sync_q[gi] <= 1'b1;
                    else          sync_q[gi] <= rx;
                end
            end else begin : g_chain
                always_ff @(posedge clk) begin
                    if (!reset_n) sync_q[gi] <= 1'b1;
                    else          sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready output, framing and overrun flags.
// Define UART_RX_PARITY_EN to add a parity bit to the frame and enable rx_parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEFAULT,
    parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter bit PARITY_ODD  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .rx     (rx),
        .rx_s   (rx_s)
    );

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 commit;
    logic                 commit_ferr;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            overrun_q <= overrun_d;
        end
    end

    // Frame FSM: advances only on oversample ticks.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_bad_d   = par_bad_q;
        commit      = 1'b0;
        commit_ferr = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        cnt_d   = '0;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == LAST_CNT) begin
                        par_bad_d = (rx_s != parity_bit(8'(shift_q), DATA_BITS, PARITY_ODD));
                        cnt_d     = '0;
                        state_d   = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == LAST_CNT) begin
                        commit      = 1'b1;
                        commit_ferr = !rx_s;
                        cnt_d       = '0;
                        state_d     = rx_s ? IDLE : BREAK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output handshake runs every clock; a commit into a full, unaccepted slot is dropped.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        overrun_d = 1'b0;
        if (commit) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ferr_d  = commit_ferr;
`ifdef UART_RX_PARITY_EN
                perr_d  = par_bad_q;
`else
                perr_d  = 1'b0;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_frame_err  = ferr_q;
    assign rx_parity_err = perr_q;
    assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clk, OVERSAMPLE=16, 8 data bits.
// Parity frames are exercised when UART_RX_PARITY_EN is defined (odd parity).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_overrun;

    int tests_run = 0;
    int tests_failed = 0;

    logic [1:0] tdiv = 2'd0;
    int         accept_cnt = 0;
    int         overrun_cnt = 0;
    int         valid_clks = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_ferr = 1'b0;
    logic       last_perr = 1'b0;
    int         base;

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .SYNC_STAGES(2),
        .PARITY_ODD (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tdiv = tdiv + 2'd1;
        tick = (tdiv == 2'd0);
    end

    // Record every accepted byte and every overrun pulse.
    always @(negedge clk) begin
        if (rx_valid) valid_clks++;
        if (rx_overrun) overrun_cnt++;
        if (rx_valid && rx_ready) begin
            accept_cnt++;
            last_data = rx_data;
            last_ferr = rx_frame_err;
            last_perr = rx_parity_err;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed no finish, expected finish before 600000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_ticks(16);
`else
        if (par) begin end
`endif
        rx = stop_bit;
        wait_ticks(16);
        if (stop_bit) rx = 1'b1;
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    initial begin
        // Reset state
        repeat (4) @(posedge clk);
        #1;
        check("reset_valid", 32'(rx_valid), 32'h0);
        check("reset_data", 32'(rx_data), 32'h0);
        check("reset_ferr", 32'(rx_frame_err), 32'h0);
        check("reset_overrun", 32'(rx_overrun), 32'h0);
        reset_n = 1'b1;
        wait_ticks(4);

        // 1: clean 0x55
        valid_clks = 0;
        send_frame(8'h55, 1'b1, odd_par(8'h55));
        wait_ticks(4);
        check("t1_accepts", 32'(accept_cnt), 32'd1);
        check("t1_data", 32'(last_data), 32'h55);
        check("t1_ferr", 32'(last_ferr), 32'h0);
        check("t1_valid_clks", 32'(valid_clks), 32'd1);
        check("t1_overrun", 32'(overrun_cnt), 32'd0);

        // 2: short glitch rejected, then 0xA3
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(24);
        check("t2_glitch_accepts", 32'(accept_cnt), 32'd1);
        send_frame(8'hA3, 1'b1, odd_par(8'hA3));
        wait_ticks(4);
        check("t2_accepts", 32'(accept_cnt), 32'd2);
        check("t2_data", 32'(last_data), 32'hA3);
        check("t2_ferr", 32'(last_ferr), 32'h0);

        // 3: stop bit low, line held low, then 0x81
        send_frame(8'h3C, 1'b0, odd_par(8'h3C));
        wait_ticks(40);
        check("t3_accepts", 32'(accept_cnt), 32'd3);
        check("t3_data", 32'(last_data), 32'h3C);
        check("t3_ferr", 32'(last_ferr), 32'h1);
        rx = 1'b1;
        wait_ticks(20);
        check("t3_break_accepts", 32'(accept_cnt), 32'd3);
        send_frame(8'h81, 1'b1, odd_par(8'h81));
        wait_ticks(4);
        check("t3_next_accepts", 32'(accept_cnt), 32'd4);
        check("t3_next_data", 32'(last_data), 32'h81);
        check("t3_next_ferr", 32'(last_ferr), 32'h0);

        // 4: overrun with consumer stalled
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, odd_par(8'h11));
        send_frame(8'h22, 1'b1, odd_par(8'h22));
        wait_ticks(4);
        check("t4_valid_held", 32'(rx_valid), 32'h1);
        check("t4_data_held", 32'(rx_data), 32'h11);
        check("t4_overrun", 32'(overrun_cnt), 32'd1);
        check("t4_no_accept", 32'(accept_cnt), 32'd4);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_valid_drop", 32'(rx_valid), 32'h0);
        check("t4_accepts", 32'(accept_cnt), 32'd5);
        check("t4_acc_data", 32'(last_data), 32'h11);

        // 6: reset mid-DATA of 0xFF while a byte is pending
        rx_ready = 1'b0;
        send_frame(8'h99, 1'b1, odd_par(8'h99));
        wait_ticks(2);
        check("t6_pending", 32'(rx_valid), 32'h1);
        rx = 1'b0;
        wait_ticks(16);
        rx = 1'b1;
        wait_ticks(40);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_rst_valid", 32'(rx_valid), 32'h0);
        check("t6_rst_data", 32'(rx_data), 32'h0);
        check("t6_rst_ferr", 32'(rx_frame_err), 32'h0);
        reset_n = 1'b1;
        rx_ready = 1'b1;
        wait_ticks(100);
        check("t6_no_valid", 32'(accept_cnt), 32'd5);
        send_frame(8'h42, 1'b1, odd_par(8'h42));
        wait_ticks(4);
        check("t6_accepts", 32'(accept_cnt), 32'd6);
        check("t6_data", 32'(last_data), 32'h42);

`ifdef UART_RX_PARITY_EN
        // 5: odd parity, 0x01 with parity bit 0 then 1
        send_frame(8'h01, 1'b1, 1'b0);
        wait_ticks(4);
        check("t5_ok_data", 32'(last_data), 32'h01);
        check("t5_ok_perr", 32'(last_perr), 32'h0);
        send_frame(8'h01, 1'b1, 1'b1);
        wait_ticks(4);
        check("t5_bad_accepts", 32'(accept_cnt), 32'd8);
        check("t5_bad_perr", 32'(last_perr), 32'h1);
`else
        check("t5_perr_tied", 32'(last_perr), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
